// File: rtl/window_3x3_gen.sv
// window_3x3_gen: builds a 3x3 neighbourhood from a raster stream using two
// line buffers, with sync/blanking delayed to stay aligned with the window.
// Two-cycle pipeline: S1 = line-buffer read + input registers,
// S2 = window shift + output registers.
module window_3x3_gen #(
  parameter int H_ACT = 640,
  parameter int DW    = 8,
  parameter int XW    = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   in_pix,
  input  logic            in_vde,
  input  logic            in_hsync,
  input  logic            in_vsync,
  input  logic [XW-1:0]   in_x,
  input  logic [XW-1:0]   in_y,
  input  logic            in_sof,
  output logic [9*DW-1:0] win,
  output logic            win_valid,
  output logic            out_vde,
  output logic            out_hsync,
  output logic            out_vsync,
  output logic [XW-1:0]   out_cx,
  output logic [XW-1:0]   out_cy
);

  localparam int AW = (H_ACT > 1) ? $clog2(H_ACT) : 1;

  // Line buffers: LB0 holds row y-1, LB1 holds row y-2
  logic [DW-1:0] lb0_mem [H_ACT];
  logic [DW-1:0] lb1_mem [H_ACT];
  logic [AW-1:0] addr;
  logic [DW-1:0] lb0_rd_q, lb1_rd_q;

  // S1 registers
  logic [DW-1:0] pix_d1_q;
  logic          vde_d1_q, hs_d1_q, vs_d1_q, sof_d1_q;
  logic [XW-1:0] x_d1_q, y_d1_q;

  // S2 registers and next-state
  logic [9*DW-1:0] win_q, win_d;
  logic [1:0]      col_cnt_q, col_cnt_d;
  logic            frame_ok_q, frame_ok_d;
  logic            valid_q, valid_d;
  logic            vde_d2_q, hs_d2_q, vs_d2_q;
  logic [XW-1:0]   cx_q, cy_q, cx_d, cy_d;

  assign addr = in_x[AW-1:0];

  // Line-buffer access: read-before-write, contents never reset
  always_ff @(posedge clk) begin
    if (in_vde) begin
      lb0_rd_q      <= lb0_mem[addr];
      lb1_rd_q      <= lb1_mem[addr];
      lb0_mem[addr] <= in_pix;
      lb1_mem[addr] <= lb0_mem[addr];
    end
  end

  // S1: register the incoming pixel, qualifiers and coordinates
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_d1_q <= '0;
      vde_d1_q <= 1'b0;
      hs_d1_q  <= 1'b1;
      vs_d1_q  <= 1'b1;
      sof_d1_q <= 1'b0;
      x_d1_q   <= '0;
      y_d1_q   <= '0;
    end else begin
      pix_d1_q <= in_pix;
      vde_d1_q <= in_vde;
      hs_d1_q  <= in_hsync;
      vs_d1_q  <= in_vsync;
      sof_d1_q <= in_sof;
      x_d1_q   <= in_x;
      y_d1_q   <= in_y;
    end
  end

  // S2 next-state: window shift, column count, frame tracking and validity
  always_comb begin
    win_d      = win_q;
    col_cnt_d  = col_cnt_q;
    frame_ok_d = frame_ok_q | sof_d1_q;
    if (vde_d1_q) begin
      win_d = {win_q[8*DW-1 -: 2*DW], lb1_rd_q,
               win_q[5*DW-1 -: 2*DW], lb0_rd_q,
               win_q[2*DW-1 -: 2*DW], pix_d1_q};
      if (x_d1_q == '0)
        col_cnt_d = 2'd1;
      else if (col_cnt_q != 2'd3)
        col_cnt_d = col_cnt_q + 2'd1;
    end
    valid_d = vde_d1_q & frame_ok_d & (col_cnt_d == 2'd3) & (y_d1_q >= XW'(2));
    cx_d    = x_d1_q - XW'(1);
    cy_d    = y_d1_q - XW'(1);
  end

  // S2: output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q      <= '0;
      col_cnt_q  <= '0;
      frame_ok_q <= 1'b0;
      valid_q    <= 1'b0;
      vde_d2_q   <= 1'b0;
      hs_d2_q    <= 1'b1;
      vs_d2_q    <= 1'b1;
      cx_q       <= '0;
      cy_q       <= '0;
    end else begin
      win_q      <= win_d;
      col_cnt_q  <= col_cnt_d;
      frame_ok_q <= frame_ok_d;
      valid_q    <= valid_d;
      vde_d2_q   <= vde_d1_q;
      hs_d2_q    <= hs_d1_q;
      vs_d2_q    <= vs_d1_q;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
    end
  end

  assign win       = win_q;
  assign win_valid = valid_q;
  assign out_vde   = vde_d2_q;
  assign out_hsync = hs_d2_q;
  assign out_vsync = vs_d2_q;
  assign out_cx    = cx_q;
  assign out_cy    = cy_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: directed bench on a reduced raster (8x6 active, 12x10 total).
module tb_window_3x3_gen;

  localparam int H_ACT = 8;
  localparam int DW    = 8;
  localparam int XW    = 10;
  localparam int HT    = 12;
  localparam int VT    = 10;
  localparam int VACT  = 6;
  localparam int HS0   = 9;
  localparam int HS1   = 10;
  localparam int VSL   = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   in_pix;
  logic            in_vde, in_hsync, in_vsync, in_sof;
  logic [XW-1:0]   in_x, in_y;
  logic [9*DW-1:0] win;
  logic            win_valid, out_vde, out_hsync, out_vsync;
  logic [XW-1:0]   out_cx, out_cy;

  window_3x3_gen #(.H_ACT(H_ACT), .DW(DW), .XW(XW)) dut (
    .clk(clk), .reset(reset), .in_pix(in_pix), .in_vde(in_vde),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_x(in_x), .in_y(in_y),
    .in_sof(in_sof), .win(win), .win_valid(win_valid), .out_vde(out_vde),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_cx(out_cx), .out_cy(out_cy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fr [VACT][H_ACT];

  // expected-value record of the previous drive cycle
  logic p_vde, p_hs, p_vs, p_fok;
  int   p_x, p_y;
  logic fok = 1'b0;

  // per-frame statistics
  int   vcnt, vcnt_after_rst, first_cx, first_cy;
  logic seen_first, ramp_seen, after_rst;
  logic last_in_hs = 1'b1, last_in_vs = 1'b1, last_in_vde = 1'b0;
  logic last_out_hs = 1'b1, last_out_vs = 1'b1, last_out_vde = 1'b0;
  time  t_in_hs, t_in_vs, t_in_vde, t_out_hs, t_out_vs, t_out_vde;

  task automatic tick_check(input logic rst, input logic sof, input logic vde,
                            input logic hs, input logic vs, input int x, input int y,
                            input logic [DW-1:0] pix);
    logic [9*DW-1:0] ewin;
    logic            ev;
    reset = rst; in_sof = sof; in_vde = vde; in_hsync = hs; in_vsync = vs;
    in_x = XW'(x); in_y = XW'(y); in_pix = pix;
    if (last_in_hs && !hs)   t_in_hs  = $time;
    if (last_in_vs && !vs)   t_in_vs  = $time;
    if (last_in_vde && !vde) t_in_vde = $time;
    last_in_hs = hs; last_in_vs = vs; last_in_vde = vde;
    @(posedge clk);
    #1;
    if (last_out_hs === 1'b1 && out_hsync === 1'b0)   t_out_hs  = $time;
    if (last_out_vs === 1'b1 && out_vsync === 1'b0)   t_out_vs  = $time;
    if (last_out_vde === 1'b1 && out_vde === 1'b0)    t_out_vde = $time;
    last_out_hs = out_hsync; last_out_vs = out_vsync; last_out_vde = out_vde;
    if (rst) begin
      tests++;
      assert ({out_vde, out_hsync, out_vsync, win_valid, win, out_cx, out_cy} ===
              {1'b0, 1'b1, 1'b1, 1'b0, {(9*DW){1'b0}}, {XW{1'b0}}, {XW{1'b0}}})
      else begin
        fails++;
        $error("FAIL reset_vals got vde=%b hs=%b vs=%b v=%b win=%h cx=%0d cy=%0d want 0,1,1,0,0,0,0",
               out_vde, out_hsync, out_vsync, win_valid, win, out_cx, out_cy);
      end
    end else begin
      ev = p_vde && p_fok && (p_x >= 2) && (p_y >= 2);
      tests++;
      assert ({out_vde, out_hsync, out_vsync, win_valid} === {p_vde, p_hs, p_vs, ev})
      else begin
        fails++;
        $error("FAIL ctrl x=%0d y=%0d got vde/hs/vs/valid=%b%b%b%b want %b%b%b%b",
               p_x, p_y, out_vde, out_hsync, out_vsync, win_valid, p_vde, p_hs, p_vs, ev);
      end
      if (ev) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            ewin[(8 - (r*3 + c))*DW +: DW] = fr[p_y-2+r][p_x-2+c];
        tests++;
        assert ({win, out_cx, out_cy} === {ewin, XW'(p_x - 1), XW'(p_y - 1)})
        else begin
          fails++;
          $error("FAIL window x=%0d y=%0d got win=%h cx=%0d cy=%0d want win=%h cx=%0d cy=%0d",
                 p_x, p_y, win, out_cx, out_cy, ewin, p_x - 1, p_y - 1);
        end
      end
    end
    if (rst) begin
      fok = 1'b0;
      p_vde = 1'b0; p_hs = 1'b1; p_vs = 1'b1;
    end else begin
      if (sof) fok = 1'b1;
      p_vde = vde; p_hs = hs; p_vs = vs;
    end
    p_fok = fok; p_x = x; p_y = y;
  endtask

  // mode 0 = ramp (x+y), mode 1 = random; reset for 3 cycles at (rx,ry) if ry>=0
  task automatic run_frame(input int mode, input int ry, input int rx);
    logic vde, hs, vs, sof, rst;
    logic [DW-1:0] pix;
    for (int y = 0; y < VACT; y++)
      for (int x = 0; x < H_ACT; x++)
        fr[y][x] = (mode == 0) ? DW'(x + y) : DW'($urandom_range(255));
    vcnt = 0; vcnt_after_rst = 0; seen_first = 1'b0; ramp_seen = 1'b0; after_rst = 1'b0;
    first_cx = -1; first_cy = -1;
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        vde = (x < H_ACT) && (y < VACT);
        hs  = !((x >= HS0) && (x <= HS1));
        vs  = (y != VSL);
        sof = (x == 0) && (y == 0);
        rst = (y == ry) && (x >= rx) && (x < rx + 3);
        pix = vde ? fr[y][x] : DW'($urandom_range(255));
        if (rst) after_rst = 1'b1;
        tick_check(rst, sof, vde, hs, vs, x, y, pix);
        if (win_valid === 1'b1) begin
          vcnt++;
          if (after_rst) vcnt_after_rst++;
          if (!seen_first) begin
            seen_first = 1'b1; first_cx = int'(out_cx); first_cy = int'(out_cy);
          end
          if (mode == 0 && out_cx == XW'(3) && out_cy == XW'(2)) begin
            ramp_seen = 1'b1;
            tests++;
            assert (win === {8'd3, 8'd4, 8'd5, 8'd4, 8'd5, 8'd6, 8'd5, 8'd6, 8'd7})
            else begin
              fails++;
              $error("FAIL ramp_golden got %h want 030405040506050607", win);
            end
          end
        end
      end
    end
  endtask

  initial begin
    // power-up reset with idle raster inputs
    for (int i = 0; i < 3; i++) tick_check(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, '0);

    // frame A: first after power-up, line buffers uninitialised
    run_frame(0, -1, 0);
    tests++;
    assert (vcnt === 24)
    else begin fails++; $error("FAIL validcnt_A got %0d want 24", vcnt); end
    tests++;
    assert (first_cx === 1 && first_cy === 1)
    else begin fails++; $error("FAIL first_valid got cx=%0d cy=%0d want 1,1", first_cx, first_cy); end
    tests++;
    assert (ramp_seen === 1'b1)
    else begin fails++; $error("FAIL ramp_seen_A got %b want 1", ramp_seen); end

    // frame B: reset mid-frame, no valid window afterwards in this frame
    run_frame(0, 3, 4);
    tests++;
    assert (vcnt_after_rst === 0)
    else begin fails++; $error("FAIL valid_after_reset got %0d want 0", vcnt_after_rst); end

    // frame C: recovers and matches the ramp golden
    run_frame(0, -1, 0);
    tests++;
    assert (vcnt === 24)
    else begin fails++; $error("FAIL validcnt_C got %0d want 24", vcnt); end
    tests++;
    assert (ramp_seen === 1'b1)
    else begin fails++; $error("FAIL ramp_seen_C got %b want 1", ramp_seen); end
    tests++;
    assert (t_out_hs - t_in_hs === 20)
    else begin fails++; $error("FAIL hsync_delay got %0t want 20", t_out_hs - t_in_hs); end
    tests++;
    assert (t_out_vs - t_in_vs === 20)
    else begin fails++; $error("FAIL vsync_delay got %0t want 20", t_out_vs - t_in_vs); end
    tests++;
    assert (t_out_vde - t_in_vde === 20)
    else begin fails++; $error("FAIL vde_delay got %0t want 20", t_out_vde - t_in_vde); end

    // frames D, E: random pixels
    for (int f = 0; f < 2; f++) begin
      run_frame(1, -1, 0);
      tests++;
      assert (vcnt === 24)
      else begin fails++; $error("FAIL validcnt_rand%0d got %0d want 24", f, vcnt); end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
